// File: rtl/m_sequence_checker.sv
// Self-synchronising checker for the 15-chip m-sequence o[n] = o[n-3] ^ o[n-4].
// Optional error counter is built only when M_SEQ_CHECK_ERR_COUNT_EN is defined.
module m_sequence_checker #(
  parameter int LOCK_COUNT  = 15,
  parameter int LOSS_THRESH = 4,
  parameter int ERR_W       = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             err_clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  typedef enum logic [1:0] {FILL, SYNC, LOCKED} state_t;

  state_t     state, state_nx;
  logic [3:0] hist, hist_nx;
  logic [2:0] fill_cnt, fill_nx;
  logic [7:0] match_cnt, match_nx;
  logic [3:0] win_cnt, win_nx;
  logic [3:0] period_err, perr_nx;
  logic       err_nx;

  logic       pred;
  logic       mismatch;
  logic [3:0] perr_inc;
  logic [2:0] fill_inc;

  assign pred     = hist[2] ^ hist[3];
  assign mismatch = in_bit ^ pred;
  assign perr_inc = period_err + {3'b000, mismatch};
  assign fill_inc = (fill_cnt == 3'd4) ? fill_cnt : fill_cnt + 3'd1;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_nx = state;
    hist_nx  = hist;
    fill_nx  = fill_cnt;
    match_nx = match_cnt;
    win_nx   = win_cnt;
    perr_nx  = period_err;
    err_nx   = 1'b0;

    if (in_valid) begin
      unique case (state)
        FILL: begin
          hist_nx = {hist[2:0], in_bit};
          fill_nx = fill_inc;
          if (fill_inc == 3'd4 && hist_nx != 4'b0000) begin
            state_nx = SYNC;
            match_nx = 8'd0;
          end
        end
        SYNC: begin
          hist_nx  = {hist[2:0], in_bit};
          match_nx = mismatch ? 8'd0 : match_cnt + 8'd1;
          if (hist_nx == 4'b0000) begin
            // The recurrence cannot leave the all-zero state, so restart the fill.
            state_nx = FILL;
            fill_nx  = 3'd0;
          end else if (!mismatch && ({1'b0, match_cnt} + 9'd1 == 9'(LOCK_COUNT))) begin
            state_nx = LOCKED;
            win_nx   = 4'd0;
            perr_nx  = 4'd0;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction, not the received chip, feeds the history.
          hist_nx = {hist[2:0], pred};
          err_nx  = mismatch;
          if (perr_inc >= 4'(LOSS_THRESH)) begin
            state_nx = FILL;
            fill_nx  = 3'd0;
          end else if (win_cnt == 4'd14) begin
            win_nx  = 4'd0;
            perr_nx = 4'd0;
          end else begin
            win_nx  = win_cnt + 4'd1;
            perr_nx = perr_inc;
          end
        end
        default: state_nx = FILL;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= FILL;
      hist       <= 4'd0;
      fill_cnt   <= 3'd0;
      match_cnt  <= 8'd0;
      win_cnt    <= 4'd0;
      period_err <= 4'd0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
    end else begin
      state      <= state_nx;
      hist       <= hist_nx;
      fill_cnt   <= fill_nx;
      match_cnt  <= match_nx;
      win_cnt    <= win_nx;
      period_err <= perr_nx;
      locked     <= (state_nx == LOCKED);
      err_pulse  <= err_nx;
    end
  end

`ifdef M_SEQ_CHECK_ERR_COUNT_EN
  // Clear beats a same-cycle error; the count saturates at all-ones.
  always_ff @(posedge clock) begin
    if (reset || err_clr) begin
      err_count <= '0;
    end else if (err_nx && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_count      = '0;
`endif

endmodule

// File: tb/tb_m_sequence_checker.sv
// Self-checking bench for m_sequence_checker: directed scenarios plus randomized
// traffic, all compared cycle by cycle against a queue-based behavioural model.
module tb_m_sequence_checker;

  localparam int LOCK_COUNT  = 15;
  localparam int LOSS_THRESH = 4;
  localparam int ERR_W       = 16;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             in_bit = 1'b0;
  logic             in_valid = 1'b0;
  logic             err_clr = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  always #5 clock = ~clock;

  m_sequence_checker #(
    .LOCK_COUNT (LOCK_COUNT),
    .LOSS_THRESH(LOSS_THRESH),
    .ERR_W      (ERR_W)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_bit   (in_bit),
    .in_valid (in_valid),
    .err_clr  (err_clr),
    .locked   (locked),
    .err_pulse(err_pulse),
    .err_count(err_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum {M_FILL, M_SYNC, M_LOCKED} mode_t;
  mode_t mode;
  bit    hq[$];              // last four history bits, oldest at index 0
  int    m_fill, m_match, m_win, m_perr, m_errs;
  bit    m_locked, m_pulse;

  bit seq [15] = '{1,1,0,1,0,1,1,1,1,0,0,0,1,0,0};
  int gen_idx = 0;

`ifdef M_SEQ_CHECK_ERR_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic model_reset();
    mode = M_FILL;
    hq.delete();
    repeat (4) hq.push_back(1'b0);
    m_fill = 0; m_match = 0; m_win = 0; m_perr = 0; m_errs = 0;
    m_locked = 0; m_pulse = 0;
  endtask

  function automatic bit hist_zero();
    return !(hq[0] | hq[1] | hq[2] | hq[3]);
  endfunction

  task automatic push_hist(input bit b);
    hq.push_back(b);
    void'(hq.pop_front());
  endtask

  task automatic model_apply(input bit v, input bit b, input bit clr);
    bit p;
    m_pulse = 0;
    if (clr) m_errs = 0;
    if (v) begin
      p = hq[0] ^ hq[1];   // o[n-4] ^ o[n-3]
      case (mode)
        M_FILL: begin
          push_hist(b);
          if (m_fill < 4) m_fill++;
          if (m_fill == 4 && !hist_zero()) begin mode = M_SYNC; m_match = 0; end
        end
        M_SYNC: begin
          push_hist(b);
          if (b == p) m_match++; else m_match = 0;
          if (hist_zero()) begin mode = M_FILL; m_fill = 0; end
          else if (m_match == LOCK_COUNT) begin mode = M_LOCKED; m_win = 0; m_perr = 0; end
        end
        default: begin
          push_hist(p);
          if (b != p) begin
            m_pulse = 1;
            m_perr++;
            if (!clr && m_errs < (1 << ERR_W) - 1) m_errs++;
          end
          if (m_perr >= LOSS_THRESH) begin mode = M_FILL; m_fill = 0; end
          else if (m_win == 14) begin m_win = 0; m_perr = 0; end
          else m_win++;
        end
      endcase
    end
    m_locked = (mode == M_LOCKED);
  endtask

  function automatic int exp_count(input int n);
    return CNT_EN ? n : 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic step(input bit v, input bit b, input bit clr, input bit rst);
    reset = rst; in_valid = v; in_bit = b; err_clr = clr;
    @(posedge clock);
    #1;
    if (rst) model_reset(); else model_apply(v, b, clr);
    check("locked", 32'(locked), 32'(m_locked));
    check("err_pulse", 32'(err_pulse), 32'(m_pulse));
    check("err_count", 32'(err_count), 32'(exp_count(m_errs)));
  endtask

  task automatic send(input bit v, input bit flip, input bit clr);
    bit b;
    b = seq[gen_idx] ^ flip;
    if (v) gen_idx = (gen_idx + 1) % 15;
    step(v, b, clr, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1);   // reset beats in_valid and err_clr
    gen_idx = 0;
  endtask

  task automatic align_window();
    for (int i = 0; i < 16 && m_win != 0; i++) send(1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    int first, acc, pulses;
    bit seen, dropped;
    model_reset();

    // Reset state
    do_reset();
    check("rst_locked", 32'(locked), 0);
    check("rst_pulse", 32'(err_pulse), 0);
    check("rst_count", 32'(err_count), 0);

    // Clean stream, valid every cycle: lock after the 19th bit
    first = -1;
    for (int i = 0; i < 25; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked && first < 0) first = i + 1;
    end
    check("lock_bits", 32'(first), 19);

    // Valid toggling: still 19 accepted bits to lock
    do_reset();
    first = -1; acc = 0;
    for (int i = 0; i < 50; i++) begin
      send(i % 2 == 0, 1'b0, 1'b0);
      if (i % 2 == 0) acc++;
      if (locked && first < 0) first = acc;
    end
    check("lock_accepted_toggle", 32'(first), 19);

    // Single inverted chip while locked
    send(1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0);
    check("single_pulse", 32'(err_pulse), 1);
    check("single_count", 32'(err_count), 32'(exp_count(1)));
    check("single_locked", 32'(locked), 1);
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0, 1'b0);
      pulses += int'(err_pulse);
    end
    check("no_propagation", 32'(pulses), 0);

    // Four errors in one window: loss of lock, then relock after 19 bits
    align_window();
    send(1'b1, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      send(1'b1, 1'b1, 1'b0);
      if (k == 2) check("locked_after_3", 32'(locked), 1);
    end
    check("loss_locked", 32'(locked), 0);
    check("loss_pulse", 32'(err_pulse), 1);
    check("loss_count", 32'(err_count), 32'(exp_count(4)));
    first = -1;
    for (int i = 0; i < 25; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked && first < 0) first = i + 1;
    end
    check("relock_bits", 32'(first), 19);

    // Three errors per window over three windows: stays locked
    align_window();
    send(1'b1, 1'b0, 1'b1);
    align_window();
    dropped = 0;
    for (int i = 0; i < 45; i++) begin
      send(1'b1, (i % 15) < 3, 1'b0);
      if (!locked) dropped = 1;
    end
    check("three_per_window_drop", 32'(dropped), 0);
    check("three_per_window_count", 32'(err_count), 32'(exp_count(9)));

    // err_clr together with an error
    send(1'b1, 1'b1, 1'b1);
    check("clr_err_pulse", 32'(err_pulse), 1);
    check("clr_err_count", 32'(err_count), 0);

    // Reset mid-LOCKED
    send(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    gen_idx = 0;
    check("midreset_locked", 32'(locked), 0);
    check("midreset_count", 32'(err_count), 0);

    // All-zero input never locks
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (locked) seen = 1;
    end
    check("zero_never_locks", 32'(seen), 0);

    // 0000 reached in SYNC returns to FILL: lock then takes a full 19 clean bits
    do_reset();
    step(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
    gen_idx = 0;
    first = -1;
    for (int i = 0; i < 25; i++) begin
      send(1'b1, 1'b0, 1'b0);
      if (locked && first < 0) first = i + 1;
    end
    check("sync_zero_relock", 32'(first), 19);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 2) begin
        do_reset();
      end else if ($urandom_range(0, 499) == 0) begin
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
      end else begin
        if ($urandom_range(0, 399) == 0) gen_idx = $urandom_range(0, 14);
        send($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3, $urandom_range(0, 99) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/m_sequence_checker.md
# m_sequence_checker

Receive-side counterpart of the 15-chip m-sequence generator (recurrence o[n] = o[n-3] XOR o[n-4], period 15; post-reset sequence 1,1,0,1,0,1,1,1,1,0,0,0,1,0,0). The checker accepts a serial bit stream and self-synchronises to it. After lock it runs a flywheel local predictor, flags and counts chip errors, and drops lock on excessive errors. It sits after the line receiver / bit slicer in the PRBS link-test path.

## Interface
- LOCK_COUNT, 15: consecutive correct predictions needed in SYNC to enter LOCKED (1..255).
- LOSS_THRESH, 4: errors within one 15-bit window that force loss of lock (1..15).
- ERR_W, 16: width of the saturating error counter.
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_bit  in  1  received chip.
- in_valid  in  1  in_bit accepted on this edge when high.
- err_clr  in  1  clears err_count.
- locked  out  1  high in LOCKED state.
- err_pulse  out  1  one-cycle pulse: last accepted bit mismatched while LOCKED.
- err_count  out  ERR_W  saturating count of LOCKED mismatches.

## Operation
- hist[3:0] holds the predictor history; hist[0] is the newest bit. The prediction for each accepted bit is p = hist[2] XOR hist[3]. On each accepted bit, hist shifts left and the new value enters hist[0].
- Cycles with in_valid low change no state and produce no pulse.
- FILL:
  - The received bit is shifted into hist, and fill_cnt increments, saturating at 4.
  - Go to SYNC (match_cnt = 0) when fill_cnt reaches 4 and the updated hist is not 0000. An all-zero hist stays in FILL.
- SYNC:
  - The received bit is shifted into hist (self-synchronising).
  - If the bit equals p, match_cnt increments. When it reaches LOCK_COUNT, go to LOCKED with win_cnt = 0 and period_err = 0.
  - If the bit differs from p, match_cnt is cleared.
  - If the updated hist is 0000, go to FILL with fill_cnt = 0.
- LOCKED (flywheel):
  - p, not the received bit, is shifted into hist.
  - If the bit differs from p: err_pulse fires, err_count increments (saturating at all-ones), and period_err increments.
  - win_cnt counts 0..14 and wraps to 0.
  - On the bit with win_cnt = 14, period_err clears to 0. Loss evaluation for that bit, including any error on it, happens before the clear.
  - If period_err, including the current bit, reaches LOSS_THRESH: go to FILL with fill_cnt = 0. locked drops and hist is retained but refilled.
- err_clr has priority over a same-cycle error: err_count becomes 0, while err_pulse still fires.
- Errors in FILL and SYNC are not counted.

## Timing
- Reset values:
  - State FILL; hist, fill_cnt, match_cnt, win_cnt, period_err all 0.
  - locked = 0, err_pulse = 0, err_count = 0.
- Reset mid-operation aborts immediately to these values. Reset wins over in_valid and err_clr.
- All outputs are registered and reflect the bit accepted on the previous edge (latency 1 clock).
- Minimum lock time is 4 + LOCK_COUNT accepted bits: with defaults, locked rises the cycle after the 19th accepted bit.
- err_pulse is high for exactly one cycle per erroneous accepted bit. Back-to-back valid error bits give consecutive pulses.
- Loss of lock: locked falls the cycle after the bit that reaches LOSS_THRESH. That bit also pulses err_pulse.

## Configuration
- M_SEQ_CHECK_ERR_COUNT_EN:
  - Defined: the ERR_W error counter and err_clr logic are built as above.
  - Undefined: err_count is tied to 0 and err_clr is ignored. err_pulse, lock and loss behaviour are unchanged.

## Test plan
- Clean stream from reset, in_valid = 1 every cycle, generator sequence from 1,1,0,1,... → locked = 0 through the 19th edge and 1 after it; err_pulse never fires; err_count = 0.
- Same stream with in_valid toggling 1,0,1,0 → lock after 19 accepted bits (38 cycles); outputs hold during invalid cycles.
- Locked, then one inverted bit → single err_pulse, err_count = 1, locked stays 1. Later valid bits match via the flywheel, with no error propagation.
- Locked, then 4 inverted bits within one 15-bit window → err_count = 4 and locked falls after the 4th; clean data then relocks after 19 more bits. 3 errors per window held for 3 windows → stays locked, err_count = 9.
- All-zero input after reset → stays in FILL, locked = 0, err_count = 0. A 0000 hist reached in SYNC returns to FILL.
- err_clr in the same cycle as an error bit → err_count = 0 and err_pulse = 1. Reset asserted mid-LOCKED → locked = 0 and err_count = 0 next cycle.
